aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule for the decryptor. It expands a 128-bit cipher key into

---
 rtl/aes_key_expand_if.sv | 29 ++
 rtl/aes_key_expand.sv | 158 +++++++++++++++
 tb/tb_aes_key_expand.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// Bus bundle for the AES-128 key-schedule block.
//   master: drives start / key_in / rk_idx, observes busy / keys_valid / rk_out
//   slave : the key-schedule block itself
//   start      : pulse, load key_in and begin expansion
//   key_in     : cipher key, [127:120] = byte 0
//   busy       : expansion in progress
//   keys_valid : all 11 round keys stored and stable
//   rk_idx     : round-key read index 0..10
//   rk_out     : registered rk[rk_idx], one cycle read latency
interface aes_key_expand_if #(
  parameter int KW = 128
);
  logic          start;
  logic [KW-1:0] key_in;
  logic          busy;
  logic          keys_valid;
  logic [3:0]    rk_idx;
  logic [KW-1:0] rk_out;

  modport master (
    output start, key_in, rk_idx,
    input  busy, keys_valid, rk_out
  );

  modport slave (
    input  start, key_in, rk_idx,
    output busy, keys_valid, rk_out
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, all 11 round keys
// held in a register file and read back by index for the inverse cipher.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : aes_key_expand_if.slave (start, key_in, busy, keys_valid, rk_idx, rk_out)
// ensbox: forward AES S-box, purely combinational.
//   a : input byte
//   y : substituted byte

module ensbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] s;
    acc = '0;
    s   = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine map.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end
endmodule

module aes_key_expand #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_expand_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, next_state;
  logic [3:0]    round;
  logic [KW-1:0] rk [0:NR];
  logic          busy, keys_valid;
  logic [KW-1:0] rk_out;
  logic          load, step;

  logic [3:0]    prev_idx;
  logic [KW-1:0] prev_key;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot, sub, t;
  logic [31:0]   n0, n1, n2, n3;
  logic [7:0]    rcon;

  assign bus.busy       = busy;
  assign bus.keys_valid = keys_valid;
  assign bus.rk_out     = rk_out;

  // Round function on the previously written key.
  assign prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;
  assign prev_key = rk[prev_idx];
  assign {w0, w1, w2, w3} = prev_key;
  assign rot = {w3[23:0], w3[31:24]};

  ensbox u_sb3 (.a(rot[31:24]), .y(sub[31:24]));
  ensbox u_sb2 (.a(rot[23:16]), .y(sub[23:16]));
  ensbox u_sb1 (.a(rot[15:8]),  .y(sub[15:8]));
  ensbox u_sb0 (.a(rot[7:0]),   .y(sub[7:0]));

  always_comb begin
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round == 4'(NR)) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      rk_out     <= '0;
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state <= next_state;
      // Read uses pre-edge contents, so a same-edge write returns the old key.
      rk_out <= (rk_idx_ok(bus.rk_idx)) ? rk[bus.rk_idx] : '0;
      if (load) begin
        rk[0]      <= bus.key_in;
        round      <= 4'd1;
        busy       <= 1'b1;
        keys_valid <= 1'b0;
      end
      if (step) begin
        rk[round] <= {n0, n1, n2, n3};
        round     <= round + 4'd1;
        if (round == 4'(NR)) begin
          busy       <= 1'b0;
          keys_valid <= 1'b1;
        end
      end
    end
  end

  function automatic logic rk_idx_ok(input logic [3:0] idx);
    return idx <= 4'(NR);
  endfunction
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized self-checking bench for aes_key_expand. A word-level FIPS-197
// key-schedule model (S-box built from the GF(2^8) generator walk) predicts
// every round key; a cycle-level expectation of busy/keys_valid/rk_out is
// checked on every falling clock edge.
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  aes_key_expand_if #(.KW(128)) bus ();

  aes_key_expand #(.NR(10), .KW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox [0:255];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [1407:0] sched(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 11; i++) r[128*i +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return r;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] s, input int i);
    return s[128*i +: 128];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycle-level expectation: cnt = edges since the accepted start (-1 = none).
  int            cnt = -1;
  logic [1407:0] m_sched = '0;
  logic [127:0]  m_reg [0:10];
  logic [127:0]  exp_rk = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    = -1;
      exp_rk = '0;
      for (int i = 0; i < 11; i++) m_reg[i] = '0;
    end else begin
      exp_rk = (bus.rk_idx <= 4'd10) ? m_reg[bus.rk_idx] : '0;
      if (cnt >= 0 && cnt < 10) begin
        cnt++;
        m_reg[cnt] = rk_of(m_sched, cnt);
      end else if (bus.start) begin
        m_sched  = sched(bus.key_in);
        m_reg[0] = bus.key_in;
        cnt      = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 128'(bus.busy), 128'(cnt >= 0 && cnt < 10));
    check("keys_valid", 128'(bus.keys_valid), 128'(cnt == 10));
    check("rk_out", bus.rk_out, exp_rk);
  end

  task automatic do_start(input logic [127:0] k);
    bus.key_in = k;
    bus.start  = 1'b1;
    @(posedge clk); #2;
    bus.start  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.keys_valid && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    bus.rk_idx = 4'(idx);
    @(posedge clk); #2;
    v = bus.rk_out;
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    logic [1407:0] s;
    logic [127:0]  v, k, k2;
    int            n;

    build_sbox();
    for (int i = 0; i < 11; i++) m_reg[i] = '0;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rk_idx = '0;

    // Pin the model with published vectors.
    s = sched(FIPS_KEY);
    check("model_fips_rk1", rk_of(s, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_rk10", rk_of(s, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    s = sched('0);
    check("model_zero_rk1", rk_of(s, 1), 128'h62636363626363636263636362636363);

    repeat (3) @(posedge clk);
    #2;
    check("reset_rk_out", bus.rk_out, '0);
    check("reset_busy", 128'(bus.busy), '0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // FIPS-197 key
    do_start(FIPS_KEY);
    check("busy_after_start", 128'(bus.busy), 128'd1);
    wait_valid(n);
    check("fips_latency", 128'(n), 128'd10);
    read_rk(1, v);  check("fips_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(2, v);  check("fips_rk2", v, 128'hf2c295f27a96b9435935807a7359f67f);
    read_rk(10, v); check("fips_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, v);  check("fips_rk0", v, FIPS_KEY);

    // All-zero key
    do_start('0);
    wait_valid(n);
    check("zero_latency", 128'(n), 128'd10);
    read_rk(0, v);  check("zero_rk0", v, '0);
    read_rk(1, v);  check("zero_rk1", v, 128'h62636363626363636263636362636363);
    read_rk(10, v); check("zero_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Descending sweep, plus out-of-range index
    s = sched('0);
    for (int i = 10; i >= 0; i--) begin
      read_rk(i, v);
      check("sweep", v, rk_of(s, i));
    end
    read_rk(12, v); check("idx12_zero", v, '0);

    // Re-key from DONE; start at cycle 5 of EXPAND is ignored
    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k;
    do_start(k);
    check("rekey_valid_drop", 128'(bus.keys_valid), '0);
    repeat (4) begin @(posedge clk); #2; end
    bus.key_in = k2;
    bus.start  = 1'b1;
    @(posedge clk); #2;
    bus.start  = 1'b0;
    wait_valid(n);
    check("rekey_remaining", 128'(n), 128'd5);
    read_rk(10, v); check("rekey_rk10", v, rk_of(sched(k), 10));

    // Asynchronous reset mid-expansion
    bus.rk_idx = 4'd10;
    do_start(k2);
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(bus.busy), '0);
    check("arst_valid", 128'(bus.keys_valid), '0);
    check("arst_rk_out", bus.rk_out, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      read_rk(i, v);
      check("post_reset_rk", v, '0);
    end

    // Random keys with random reads and ignored starts during expansion
    for (int r = 0; r < 1000; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k);
      n = 0;
      while (!bus.keys_valid && n < 40) begin
        bus.rk_idx = 4'($urandom_range(0, 15));
        bus.start  = ($urandom_range(0, 7) == 0);
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #2;
        n++;
      end
      bus.start = 1'b0;
      check("rand_latency", 128'(n - 1), 128'd9);
      s = sched(k);
      for (int i = 10; i >= 0; i--) begin
        read_rk(i, v);
        check("rand_rk", v, rk_of(s, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
